// File: rtl/ref_clk_training_pkg.sv
// ref_clk_training_pkg: shared FSM states, sample classes and failure codes for reference-clock training.
package ref_clk_training_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_STEP, S_DONE, S_FAIL} state_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_ONE, CLS_MIXED} cls_e;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_RANGE    = 2'b01;
  localparam logic [1:0] FC_NO_EDGE  = 2'b10;
  localparam logic [1:0] FC_UNSTABLE = 2'b11;
endpackage

// File: rtl/ref_clk_word_classify.sv
// ref_clk_word_classify: sorts a deserialised reference-clock word into all-zero, all-one or mixed.
module ref_clk_word_classify
  import ref_clk_training_pkg::*;
(
  input  logic [7:0] word,
  output cls_e       cls
);
  always_comb cls = (word == 8'h00) ? CLS_ZERO : (word == 8'hFF) ? CLS_ONE : CLS_MIXED;
endmodule

// File: rtl/ref_clk_training_ctrl.sv
// ref_clk_training_ctrl: sweeps the IOD delay one tap at a time until the sampled reference clock changes class.
module ref_clk_training_ctrl
  import ref_clk_training_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_TAPS      = 128
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [1:0] FAIL_CODE,
  output logic [7:0] EDGE_TAP,
  output logic [7:0] TAP_COUNT,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  output logic [1:0] EYE_FLAGS,
  input  logic [7:0] RX_DATA_0
);
  state_e     state, state_d;
  cls_e       cls, ref_cls;
  logic [7:0] settle_cnt;
  logic [1:0] code_d;
  logic       edge_hit, last_tap;

  ref_clk_word_classify u_classify (.word(RX_DATA_0), .cls(cls));

  assign edge_hit = (TAP_COUNT != 8'd0) && (cls != ref_cls);
  assign last_tap = TAP_COUNT == 8'(MAX_TAPS - 1);

  assign BUSY                      = state != S_IDLE;
  assign DONE                      = state == S_DONE;
  assign FAIL                      = state == S_FAIL;
  assign DELAY_LINE_LOAD_0         = state == S_LOAD;
  assign DELAY_LINE_MOVE_0         = state == S_STEP;
  assign EYE_MONITOR_CLEAR_FLAGS_0 = state == S_CLEAR;

  always_comb begin
    state_d = state;
    code_d  = FC_NONE;
    case (state)
      S_IDLE:   state_d = START ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_CLEAR;
      S_CLEAR:  state_d = S_SETTLE;
      S_SETTLE: state_d = (settle_cnt == 8'(SETTLE_CYCLES - 1)) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: begin
        // out-of-range outranks an edge seen on the same tap
        code_d  = DELAY_LINE_OUT_OF_RANGE_0 ? FC_RANGE :
                  (TAP_COUNT == 8'd0 && cls == CLS_MIXED) ? FC_UNSTABLE :
                  (!edge_hit && last_tap) ? FC_NO_EDGE : FC_NONE;
        state_d = (code_d != FC_NONE) ? S_FAIL : edge_hit ? S_DONE : S_STEP;
      end
      S_STEP:   state_d = S_CLEAR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state                  <= S_IDLE;
      ref_cls                <= CLS_ZERO;
      settle_cnt             <= '0;
      TAP_COUNT              <= '0;
      EDGE_TAP               <= '0;
      FAIL_CODE              <= '0;
      EYE_FLAGS              <= '0;
      DELAY_LINE_DIRECTION_0 <= 1'b0;
    end else begin
      state                  <= state_d;
      DELAY_LINE_DIRECTION_0 <= 1'b1;
      settle_cnt             <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      if (state == S_IDLE && START) begin
        TAP_COUNT <= '0;
        EDGE_TAP  <= '0;
        FAIL_CODE <= '0;
        EYE_FLAGS <= '0;
      end
      if (state == S_SAMPLE && TAP_COUNT == 8'd0) ref_cls <= cls;
      if (state == S_SAMPLE && state_d == S_DONE) begin
        EDGE_TAP  <= TAP_COUNT;
        EYE_FLAGS <= {EYE_MONITOR_LATE_0, EYE_MONITOR_EARLY_0};
      end
      if (state == S_SAMPLE && code_d != FC_NONE) FAIL_CODE <= code_d;
      if (state == S_STEP && TAP_COUNT != 8'hFF) TAP_COUNT <= TAP_COUNT + 8'd1;
    end
  end
endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
// tb_ref_clk_training_ctrl: directed training scenarios with hand-computed cycle counts and results.
module tb_ref_clk_training_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail, load, move, dir, clr;
  logic [1:0] fail_code, eye_flags;
  logic [7:0] edge_tap, tap;
  logic       early = 1'b0, late = 1'b0;
  logic [7:0] lo = 8'h00, hi = 8'hFF, edge_at = 8'd255;
  logic       oor_en = 1'b0;
  logic [7:0] oor_tap = 8'd0;
  logic [7:0] rx;
  logic       oor;
  int total = 0, bad = 0;
  int cyc, n_move, n_load, n_clr, n_done, n_fail, done_cyc, fail_cyc, move1_cyc, poke_cyc;

  always #5 clk = ~clk;

  // reference-clock environment: the sampled word flips once the delay reaches edge_at
  assign rx  = (tap >= edge_at) ? hi : lo;
  assign oor = oor_en && (tap == oor_tap);

  ref_clk_training_ctrl #(.SETTLE_CYCLES(8), .MAX_TAPS(16)) dut (
    .FAB_CLK(clk), .RESET(rst), .START(start), .BUSY(busy), .DONE(done), .FAIL(fail),
    .FAIL_CODE(fail_code), .EDGE_TAP(edge_tap), .TAP_COUNT(tap),
    .DELAY_LINE_LOAD_0(load), .DELAY_LINE_MOVE_0(move), .DELAY_LINE_DIRECTION_0(dir),
    .DELAY_LINE_OUT_OF_RANGE_0(oor), .EYE_MONITOR_CLEAR_FLAGS_0(clr),
    .EYE_MONITOR_EARLY_0(early), .EYE_MONITOR_LATE_0(late), .EYE_FLAGS(eye_flags), .RX_DATA_0(rx)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycle 0 is the START cycle; each loop pass observes the state of cycle cyc
  task automatic train(input int budget);
    n_move = 0; n_load = 0; n_clr = 0; n_done = 0; n_fail = 0;
    done_cyc = -1; fail_cyc = -1; move1_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < budget) begin
      if (move && move1_cyc < 0) move1_cyc = cyc;
      n_move += int'(move); n_load += int'(load); n_clr += int'(clr);
      n_done += int'(done); n_fail += int'(fail);
      if (done) done_cyc = cyc;
      if (fail) fail_cyc = cyc;
      start = (cyc == poke_cyc);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("timeout", int'(busy), 0);
  endtask

  initial begin
    poke_cyc = -1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_tap", int'(tap), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_code", int'(fail_code), 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_dir", int'(dir), 1);
    chk("idle_busy", int'(busy), 0);

    // edge at tap 5
    edge_at = 8'd5; early = 1'b1; late = 1'b0;
    train(400);
    chk("e5_load", n_load, 1);
    chk("e5_clr", n_clr, 6);
    chk("e5_move1", move1_cyc, 12);
    chk("e5_moves", n_move, 5);
    chk("e5_done_cyc", done_cyc, 67);
    chk("e5_dones", n_done, 1);
    chk("e5_fails", n_fail, 0);
    chk("e5_edge", int'(edge_tap), 5);
    chk("e5_eye", int'(eye_flags), 2'b01);
    chk("e5_tap", int'(tap), 5);

    // mixed word at tap 0
    lo = 8'h3C; hi = 8'h3C; edge_at = 8'd255;
    train(400);
    chk("mix_fail_cyc", fail_cyc, 12);
    chk("mix_fails", n_fail, 1);
    chk("mix_code", int'(fail_code), 2'b11);
    chk("mix_moves", n_move, 0);
    chk("mix_edge", int'(edge_tap), 0);
    chk("mix_eye", int'(eye_flags), 0);

    // no edge across 16 taps
    lo = 8'hFF; hi = 8'hFF;
    train(400);
    chk("ne_fail_cyc", fail_cyc, 177);
    chk("ne_code", int'(fail_code), 2'b10);
    chk("ne_tap", int'(tap), 15);
    chk("ne_moves", n_move, 15);
    chk("ne_dones", n_done, 0);

    // out-of-range on the same tap as the edge
    lo = 8'h00; hi = 8'hFF; edge_at = 8'd3; oor_en = 1'b1; oor_tap = 8'd3;
    train(400);
    chk("oor_fail_cyc", fail_cyc, 45);
    chk("oor_code", int'(fail_code), 2'b01);
    chk("oor_moves", n_move, 3);
    chk("oor_dones", n_done, 0);
    chk("oor_edge", int'(edge_tap), 0);
    oor_en = 1'b0;

    // reset while settling at tap 2
    edge_at = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (27) tick();
    chk("mid_tap", int'(tap), 2);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_tap", int'(tap), 0);
    chk("ar_clr", int'(clr), 0);
    chk("ar_dir", int'(dir), 0);
    tick();
    rst = 1'b0;
    n_load = 0;
    repeat (6) begin
      n_load += int'(load);
      tick();
    end
    chk("ar_noload", n_load, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_restart_load", int'(load), 1);
    chk("ar_restart_tap", int'(tap), 0);
    repeat (2) tick();
    chk("ar_restart_clr", int'(clr), 0);
    repeat (200) if (busy) tick();
    chk("ar_finish", int'(busy), 0);
    chk("ar_edge", int'(edge_tap), 5);

    // START pulsed while busy is ignored
    edge_at = 8'd2; early = 1'b0; late = 1'b1; poke_cyc = 20;
    train(400);
    poke_cyc = -1;
    chk("pk_done_cyc", done_cyc, 34);
    chk("pk_dones", n_done, 1);
    chk("pk_loads", n_load, 1);
    chk("pk_edge", int'(edge_tap), 2);
    chk("pk_eye", int'(eye_flags), 2'b10);
    repeat (3) tick();
    chk("pk_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ref_clk_training_ctrl.md
REF_CLK_TRAINING_CTRL -- requirements
Module: ref_clk_training_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: idle cycles after each flag clear before sampling, range 1..255.
REQ-002 SHALL have parameter MAX_TAPS, default 128: maximum delay taps swept, range 2..256.
REQ-003 SHALL have port FAB_CLK, in, 1, the single clock for all logic.
REQ-004 SHALL have port RESET, in, 1, asynchronous active-high reset.
REQ-005 SHALL have port START, in, 1, training request, sampled high in IDLE only.
REQ-006 SHALL have port BUSY, out, 1, high in every state except IDLE.
REQ-007 SHALL have port DONE, out, 1, one-cycle pulse on success.
REQ-008 SHALL have port FAIL, out, 1, one-cycle pulse on failure.
REQ-009 SHALL have port FAIL_CODE, out, 2: 01 out-of-range, 10 no edge, 11 unstable reference; held until next START.
REQ-010 SHALL have port EDGE_TAP, out, 8, tap index of the detected edge; held until next START.
REQ-011 SHALL have port TAP_COUNT, out, 8, current tap index.
REQ-012 SHALL have port DELAY_LINE_LOAD_0, out, 1, reloads the IOD delay to its static value.
REQ-013 SHALL have port DELAY_LINE_MOVE_0, out, 1, one-tap step strobe.
REQ-014 SHALL have port DELAY_LINE_DIRECTION_0, out, 1, held at 1 (increment).
REQ-015 SHALL have port DELAY_LINE_OUT_OF_RANGE_0, in, 1, IOD delay limit flag.
REQ-016 SHALL have port EYE_MONITOR_CLEAR_FLAGS_0, out, 1, clear strobe for the eye monitor flags.
REQ-017 SHALL have ports EYE_MONITOR_EARLY_0 and EYE_MONITOR_LATE_0, in, 1 each, eye monitor flags.
REQ-018 SHALL have port EYE_FLAGS, out, 2, {LATE,EARLY} captured at the edge tap.
REQ-019 SHALL have port RX_DATA_0, in, 8, deserialised reference-clock samples.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, DONE, FAIL.
REQ-021 SHALL go IDLE->LOAD on START=1, clearing TAP_COUNT, EDGE_TAP, FAIL_CODE and EYE_FLAGS.
REQ-022 SHALL drive DELAY_LINE_LOAD_0=1 for exactly the one LOAD cycle, then go to CLEAR.
REQ-023 SHALL drive EYE_MONITOR_CLEAR_FLAGS_0=1 for exactly the one CLEAR cycle, then go to SETTLE.
REQ-024 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-025 SHALL classify RX_DATA_0 in SAMPLE: 0x00=ZERO, 0xFF=ONE, any other value=MIXED.
REQ-026 SHALL store the class at tap 0 as the reference class, and go to FAIL with code 11 if that class is MIXED.
REQ-027 SHALL treat an edge as found at the first tap above 0 whose class differs from the reference class; it SHALL latch TAP_COUNT into EDGE_TAP and the eye flags into EYE_FLAGS, then go to DONE.
REQ-028 SHALL go to FAIL with code 01 if DELAY_LINE_OUT_OF_RANGE_0=1 in SAMPLE; this check takes priority over edge detection.
REQ-029 SHALL go to FAIL with code 10 if no edge is found and TAP_COUNT=MAX_TAPS-1.
REQ-030 SHALL otherwise go to STEP, pulse DELAY_LINE_MOVE_0 for one cycle, increment TAP_COUNT (8-bit, never wraps), then go to CLEAR.
REQ-031 SHALL pulse DONE or FAIL in the corresponding state for one cycle, then return to IDLE with the delay line left at the final tap.
REQ-032 SHALL ignore START whenever the FSM is outside IDLE.
REQ-033 SHALL give a per-tap period of SETTLE_CYCLES+3 cycles; the tap-0 SAMPLE SHALL fall SETTLE_CYCLES+3 cycles after the START cycle.

Reset
REQ-034 SHALL, on RESET=1, asynchronously force state IDLE and drive every output and register to 0, including in mid-sweep.
REQ-035 SHALL not reload the delay line after reset until the next START.

Structure
REQ-036 SHALL place the state enum, the class enum (ZERO, ONE, MIXED) and the FAIL_CODE constants in the shared package ref_clk_training_pkg.
REQ-037 SHALL place the combinational classifier in one sub-module, ref_clk_word_classify.

Verification
REQ-038 SHALL cover: SETTLE_CYCLES=8, RX_DATA_0=0x00 for taps 0-4 and 0xFF from tap 5 -> SAMPLE at tap 5 in cycle 66 after START, DONE in cycle 67, EDGE_TAP=5, five MOVE pulses.
REQ-039 SHALL cover: RX_DATA_0=0x3C at tap 0 -> FAIL, FAIL_CODE=11, no MOVE pulses.
REQ-040 SHALL cover: MAX_TAPS=16, RX_DATA_0 held at 0xFF -> FAIL, FAIL_CODE=10, TAP_COUNT=15, fifteen MOVE pulses.
REQ-041 SHALL cover: OUT_OF_RANGE=1 at tap 3 coinciding with an edge -> FAIL, FAIL_CODE=01.
REQ-042 SHALL cover: RESET asserted during SETTLE at tap 2 -> all outputs 0 immediately; a later START restarts with LOAD.
REQ-043 SHALL cover: START pulsed while BUSY -> no effect, single DONE.
